// File: rtl/bsg_manycore_host_packet_bridge.sv
// bsg_manycore_host_packet_bridge
//
// Purpose:
//   Bridges the host MMIO word interface and the manycore loader link port.
//   Host writes are gathered, least-significant word first, into one forward
//   request packet. That packet goes to the manycore under a credit limit on
//   outstanding requests. Each returned response packet is handed back to the
//   host as a series of 32-bit words, least-significant word first. A credit
//   comes back only after the last word of a response has been read by the host.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   host_wdata_i / host_wv_i    host write word and valid
//   host_wready_o               bridge can accept a host word this cycle
//   host_rdata_o / host_rv_o    response word to host and valid
//   host_rready_i               host takes the response word this cycle
//   fwd_packet_o / fwd_v_o      forward packet to manycore and valid
//   fwd_ready_i                 link accepts the forward packet
//   ret_packet_i / ret_v_i      returned packet from manycore and valid
//   ret_yumi_o                  bridge consumes ret_packet_i this cycle
//   credits_o                   credits currently available for sending

module bsg_manycore_host_packet_bridge #(
    parameter int fwd_width_p       = 128,
    parameter int ret_width_p       = 64,
    parameter int max_out_credits_p = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [31:0]                            host_wdata_i,
    input  logic                                   host_wv_i,
    output logic                                   host_wready_o,
    output logic [31:0]                            host_rdata_o,
    output logic                                   host_rv_o,
    input  logic                                   host_rready_i,
    output logic [fwd_width_p-1:0]                 fwd_packet_o,
    output logic                                   fwd_v_o,
    input  logic                                   fwd_ready_i,
    input  logic [ret_width_p-1:0]                 ret_packet_i,
    input  logic                                   ret_v_i,
    output logic                                   ret_yumi_o,
    output logic [$clog2(max_out_credits_p+1)-1:0] credits_o
);

    localparam int fwd_words_lp  = (fwd_width_p + 31) / 32;
    localparam int ret_words_lp  = (ret_width_p + 31) / 32;
    localparam int tx_cnt_w_lp   = (fwd_words_lp > 1) ? $clog2(fwd_words_lp) : 1;
    localparam int rx_cnt_w_lp   = (ret_words_lp > 1) ? $clog2(ret_words_lp) : 1;
    localparam int credit_w_lp   = $clog2(max_out_credits_p + 1);
    localparam int fwd_flat_w_lp = fwd_words_lp * 32;
    localparam int ret_flat_w_lp = ret_words_lp * 32;

    typedef enum logic {
        TX_ACCUM,
        TX_SEND
    } tx_state_e;

    typedef enum logic {
        RX_WAIT,
        RX_DRAIN
    } rx_state_e;

    tx_state_e                tx_state_r;
    logic [tx_cnt_w_lp-1:0]   tx_cnt_r;
    logic [31:0]              tx_words_r [fwd_words_lp];
    logic [fwd_flat_w_lp-1:0] tx_flat;

    rx_state_e                rx_state_r;
    logic [rx_cnt_w_lp-1:0]   rx_cnt_r;
    logic [31:0]              rx_words_r [ret_words_lp];
    logic [ret_flat_w_lp-1:0] ret_flat;

    logic [credit_w_lp-1:0]   credits_r;

    logic host_w_xfer;
    logic host_r_xfer;
    logic fwd_xfer;
    logic rx_last;
    logic credit_inc;
    logic credit_dec;

    // Handshakes and the credit events derived from them
    assign host_w_xfer = host_wv_i & host_wready_o;
    assign host_r_xfer = host_rv_o & host_rready_i;
    assign fwd_xfer    = fwd_v_o & fwd_ready_i;
    assign rx_last     = (rx_cnt_r == rx_cnt_w_lp'(ret_words_lp - 1));
    assign credit_dec  = fwd_xfer;
    assign credit_inc  = host_r_xfer & rx_last;

    // Outputs are plain decodes of registered state, so none of them depends
    // combinationally on its own handshake input. The one exception is
    // ret_yumi_o, which is the consume strobe that the link protocol expects.
    assign host_wready_o = (tx_state_r == TX_ACCUM);
    // Valid is gated by credits only while SEND is held. Credits can only fall
    // on a send, so once valid is high it stays high until the packet is taken.
    assign fwd_v_o       = (tx_state_r == TX_SEND) && (credits_r != '0);
    assign fwd_packet_o  = tx_flat[fwd_width_p-1:0];
    assign host_rv_o     = (rx_state_r == RX_DRAIN);
    assign host_rdata_o  = rx_words_r[rx_cnt_r];
    assign ret_yumi_o    = ret_v_i & (rx_state_r == RX_WAIT);
    assign credits_o     = credits_r;

    // Flatten the word slots into the forward packet, slot 0 in the low bits
    always_comb begin
        tx_flat = '0;
        for (int i = 0; i < fwd_words_lp; i++) begin
            tx_flat[i*32 +: 32] = tx_words_r[i];
        end
    end

    // Zero-extend the returned packet so the top host word is zero-filled
    assign ret_flat = ret_flat_w_lp'(ret_packet_i);

    // TX path: fill slots one host word at a time. Stop taking words while the
    // finished packet is waiting for the link, so the packet stays stable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tx_state_r <= TX_ACCUM;
            tx_cnt_r   <= '0;
            for (int i = 0; i < fwd_words_lp; i++) begin
                tx_words_r[i] <= '0;
            end
        end else begin
            case (tx_state_r)
                TX_ACCUM: begin
                    if (host_w_xfer) begin
                        tx_words_r[tx_cnt_r] <= host_wdata_i;
                        if (tx_cnt_r == tx_cnt_w_lp'(fwd_words_lp - 1)) begin
                            tx_cnt_r   <= '0;
                            tx_state_r <= TX_SEND;
                        end else begin
                            tx_cnt_r <= tx_cnt_r + tx_cnt_w_lp'(1);
                        end
                    end
                end
                TX_SEND: begin
                    if (fwd_xfer) begin
                        tx_state_r <= TX_ACCUM;
                    end
                end
                default: tx_state_r <= TX_ACCUM;
            endcase
        end
    end

    // RX path: take one returned packet while idle, then feed it to the host
    // one word per host read. No new packet is consumed until the drain ends.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state_r <= RX_WAIT;
            rx_cnt_r   <= '0;
            for (int i = 0; i < ret_words_lp; i++) begin
                rx_words_r[i] <= '0;
            end
        end else begin
            case (rx_state_r)
                RX_WAIT: begin
                    if (ret_v_i) begin
                        for (int i = 0; i < ret_words_lp; i++) begin
                            rx_words_r[i] <= ret_flat[i*32 +: 32];
                        end
                        rx_cnt_r   <= '0;
                        rx_state_r <= RX_DRAIN;
                    end
                end
                RX_DRAIN: begin
                    if (host_r_xfer) begin
                        if (rx_last) begin
                            rx_state_r <= RX_WAIT;
                        end else begin
                            rx_cnt_r <= rx_cnt_r + rx_cnt_w_lp'(1);
                        end
                    end
                end
                default: rx_state_r <= RX_WAIT;
            endcase
        end
    end

    // Credit counter: a send and a final drain in the same cycle cancel out
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r <= credit_w_lp'(max_out_credits_p);
        end else begin
            case ({credit_dec, credit_inc})
                2'b10:   credits_r <= credits_r - credit_w_lp'(1);
                2'b01:   credits_r <= credits_r + credit_w_lp'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response that has no matching outstanding request would push the
    // credit count past its maximum.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && credit_inc && !credit_dec) begin
            assert (credits_r < credit_w_lp'(max_out_credits_p));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_host_packet_bridge.sv
// tb_bsg_manycore_host_packet_bridge
//
// Directed scenarios are followed by a randomized full-duplex run. The run is
// checked against a queue-based model. Host words are collected in groups of
// four to form expected packets. Returned packets are split into expected host
// words. Credits are the maximum minus the number of requests sent and not yet
// fully drained.

module tb_bsg_manycore_host_packet_bridge;

    logic         clk_i;
    logic         reset_n_i;
    logic [31:0]  host_wdata_i;
    logic         host_wv_i;
    logic         host_wready_o;
    logic [31:0]  host_rdata_o;
    logic         host_rv_o;
    logic         host_rready_i;
    logic [127:0] fwd_packet_o;
    logic         fwd_v_o;
    logic         fwd_ready_i;
    logic [63:0]  ret_packet_i;
    logic         ret_v_i;
    logic         ret_yumi_o;
    logic [4:0]   credits_o;

    int total;
    int bad;

    bsg_manycore_host_packet_bridge #(
        .fwd_width_p      (128),
        .ret_width_p      (64),
        .max_out_credits_p(16)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .host_wdata_i (host_wdata_i),
        .host_wv_i    (host_wv_i),
        .host_wready_o(host_wready_o),
        .host_rdata_o (host_rdata_o),
        .host_rv_o    (host_rv_o),
        .host_rready_i(host_rready_i),
        .fwd_packet_o (fwd_packet_o),
        .fwd_v_o      (fwd_v_o),
        .fwd_ready_i  (fwd_ready_i),
        .ret_packet_i (ret_packet_i),
        .ret_v_i      (ret_v_i),
        .ret_yumi_o   (ret_yumi_o),
        .credits_o    (credits_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Move to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive every input, then let combinational outputs settle before checking
    task automatic applyStimulus(input logic wv, input logic [31:0] wdata,
                                 input logic fready, input logic retv,
                                 input logic [63:0] retpkt, input logic rready);
        host_wv_i     = wv;
        host_wdata_i  = wdata;
        fwd_ready_i   = fready;
        ret_v_i       = retv;
        ret_packet_i  = retpkt;
        host_rready_i = rready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic writeWord(input logic [31:0] data, input logic fready);
        applyStimulus(1'b1, data, fready, 1'b0, 64'd0, 1'b0);
        checkOutput("wready_on_write", host_wready_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, fready, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic writePacket(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic fready);
        writeWord(w0, fready);
        writeWord(w1, fready);
        writeWord(w2, fready);
        writeWord(w3, fready);
    endtask

    // RX is in DRAIN: read both words with host_rready_i held high
    task automatic drainReturn(input logic [63:0] pkt);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("drain_rv0", host_rv_o, 1'b1);
        checkOutput("drain_word0", host_rdata_o, pkt[31:0]);
        tick();
        checkOutput("drain_rv1", host_rv_o, 1'b1);
        checkOutput("drain_word1", host_rdata_o, pkt[63:32]);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("drain_rv_done", host_rv_o, 1'b0);
    endtask

    task automatic deliverReturn(input logic [63:0] pkt);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, pkt, 1'b0);
        checkOutput("ret_yumi", ret_yumi_o, 1'b1);
        tick();
        drainReturn(pkt);
    endtask

    // Reference model state for the randomized run
    logic [31:0]  wq[$];
    logic [31:0]  rq[$];
    logic [127:0] pend_pkt;
    bit           pending;
    int           sent;
    int           drained;
    int           ret_acc;

    initial begin
        logic [127:0] held_pkt;
        logic [63:0]  p4;
        logic [63:0]  p4b;
        logic         rr;
        int           ptr;
        logic         r_wv, r_fr, r_retv, r_rr;
        logic [31:0]  r_wdata;
        logic [63:0]  r_pkt;
        logic [4:0]   exp_credits;
        logic         exp_wready, exp_v, exp_rv, exp_yumi;
        logic         wt, ft, rt, yt;

        total = 0;
        bad   = 0;

        // Reset
        reset_n_i = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("rst_wready", host_wready_o, 1'b1);
        checkOutput("rst_rv", host_rv_o, 1'b0);
        checkOutput("rst_fwd_v", fwd_v_o, 1'b0);
        checkOutput("rst_yumi", ret_yumi_o, 1'b0);
        checkOutput("rst_credits", credits_o, 5'd16);
        reset_n_i = 1'b1;

        // Test 1: one packet assembled LSW first and sent immediately
        $display("[TB] basic packet");
        writePacket(32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
        checkOutput("t1_fwd_v", fwd_v_o, 1'b1);
        checkOutput("t1_pkt", fwd_packet_o, 128'h00000044_00000033_00000022_00000011);
        checkOutput("t1_wready_low", host_wready_o, 1'b0);
        checkOutput("t1_credits_before", credits_o, 5'd16);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("t1_wready_back", host_wready_o, 1'b1);
        checkOutput("t1_fwd_v_drop", fwd_v_o, 1'b0);
        checkOutput("t1_credits_after", credits_o, 5'd15);

        // Test 2: backpressure holds the packet stable and blocks the next host word
        $display("[TB] backpressure");
        writePacket(32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);
        held_pkt = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 32'hB0, 1'b0, 1'b0, 64'd0, 1'b0);
            checkOutput("t2_fwd_v_held", fwd_v_o, 1'b1);
            checkOutput("t2_pkt_stable", fwd_packet_o, held_pkt);
            checkOutput("t2_wready_blocked", host_wready_o, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'hB0, 1'b1, 1'b0, 64'd0, 1'b0);
        checkOutput("t2_fwd_v_before_hs", fwd_v_o, 1'b1);
        tick();
        checkOutput("t2_wready_after_hs", host_wready_o, 1'b1);
        checkOutput("t2_fwd_v_after_hs", fwd_v_o, 1'b0);
        checkOutput("t2_credits", credits_o, 5'd14);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        writeWord(32'hB1, 1'b1);
        writeWord(32'hB2, 1'b1);
        writeWord(32'hB3, 1'b1);
        checkOutput("t2_second_pkt", fwd_packet_o, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        checkOutput("t2_second_v", fwd_v_o, 1'b1);
        tick();
        checkOutput("t2_credits_after", credits_o, 5'd13);

        // Test 3: exhaust credits, then one return releases the waiting packet
        $display("[TB] credit exhaustion");
        for (int i = 0; i < 13; i++) begin
            writePacket(32'h100 + 32'(i * 4), 32'h101 + 32'(i * 4),
                        32'h102 + 32'(i * 4), 32'h103 + 32'(i * 4), 1'b1);
            checkOutput("t3_fill_v", fwd_v_o, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("t3_credits_zero", credits_o, 5'd0);
        writePacket(32'hD0, 32'hD1, 32'hD2, 32'hD3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0);
            checkOutput("t3_blocked_v", fwd_v_o, 1'b0);
            checkOutput("t3_blocked_wready", host_wready_o, 1'b0);
            tick();
        end
        deliverReturn(64'h12345678_9ABCDEF0);
        checkOutput("t3_credits_one", credits_o, 5'd1);
        checkOutput("t3_v_rises", fwd_v_o, 1'b1);
        checkOutput("t3_pkt", fwd_packet_o, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("t3_credits_back_zero", credits_o, 5'd0);
        checkOutput("t3_v_done", fwd_v_o, 1'b0);

        // Test 5: send and final drain in the same cycle leave credits unchanged
        $display("[TB] simultaneous send and drain");
        deliverReturn(64'h00000001_00000002);
        deliverReturn(64'h00000003_00000004);
        deliverReturn(64'h00000005_00000006);
        checkOutput("t5_credits_three", credits_o, 5'd3);
        writePacket(32'hE0, 32'hE1, 32'hE2, 32'hE3, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 64'hCAFEF00D_55AA55AA, 1'b0);
        checkOutput("t5_yumi", ret_yumi_o, 1'b1);
        checkOutput("t5_v", fwd_v_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("t5_word0", host_rdata_o, 32'h55AA55AA);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b1);
        checkOutput("t5_word1", host_rdata_o, 32'hCAFEF00D);
        checkOutput("t5_v_at_same", fwd_v_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("t5_credits_kept", credits_o, 5'd3);
        checkOutput("t5_v_off", fwd_v_o, 1'b0);
        checkOutput("t5_rv_off", host_rv_o, 1'b0);

        // Test 4: drain with toggling host ready while a second return waits
        $display("[TB] response serialisation");
        p4  = 64'hDEADBEEF_01234567;
        p4b = 64'h0BADF00D_CAFE0001;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, p4, 1'b0);
        checkOutput("t4_yumi_first", ret_yumi_o, 1'b1);
        tick();
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            rr = (k % 2) == 1;
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, p4b, rr);
            checkOutput("t4_rv", host_rv_o, 1'b1);
            checkOutput("t4_yumi_blocked", ret_yumi_o, 1'b0);
            checkOutput("t4_rdata", host_rdata_o, (ptr == 0) ? 32'h01234567 : 32'hDEADBEEF);
            tick();
            if (rr) ptr++;
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, p4b, 1'b0);
        checkOutput("t4_yumi_second", ret_yumi_o, 1'b1);
        checkOutput("t4_rv_idle", host_rv_o, 1'b0);
        checkOutput("t4_credits", credits_o, 5'd4);
        tick();
        drainReturn(p4b);
        checkOutput("t4_credits_after", credits_o, 5'd5);

        // Test 6: reset mid-accumulation and mid-drain
        $display("[TB] reset mid-traffic");
        writePacket(32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b1);
        tick();
        writeWord(32'h77, 1'b0);
        writeWord(32'h88, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 64'h11112222_33334444, 1'b0);
        checkOutput("t6_yumi", ret_yumi_o, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b1);
        checkOutput("t6_word0", host_rdata_o, 32'h33334444);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("t6_mid_drain_rv", host_rv_o, 1'b1);
        #2;
        reset_n_i = 1'b0;
        #1;
        checkOutput("t6_rst_wready", host_wready_o, 1'b1);
        checkOutput("t6_rst_rv", host_rv_o, 1'b0);
        checkOutput("t6_rst_fwd_v", fwd_v_o, 1'b0);
        checkOutput("t6_rst_yumi", ret_yumi_o, 1'b0);
        checkOutput("t6_rst_credits", credits_o, 5'd16);
        tick();
        reset_n_i = 1'b1;
        writePacket(32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b0);
        checkOutput("t6_fresh_v", fwd_v_o, 1'b1);
        checkOutput("t6_fresh_pkt", fwd_packet_o, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        checkOutput("t6_credits", credits_o, 5'd15);

        // Randomized full-duplex run against the queue model
        $display("[TB] randomized full-duplex run");
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        pending = 0;
        sent    = 0;
        drained = 0;
        ret_acc = 0;
        wq.delete();
        rq.delete();
        for (int c = 0; c < 1500; c++) begin
            r_wv    = ($urandom_range(0, 1) == 1);
            r_wdata = $urandom;
            r_fr    = ($urandom_range(0, 3) != 0);
            r_retv  = (ret_acc < sent) && ($urandom_range(0, 3) == 0);
            r_pkt   = {$urandom, $urandom};
            r_rr    = ($urandom_range(0, 1) == 1);
            applyStimulus(r_wv, r_wdata, r_fr, r_retv, r_pkt, r_rr);

            exp_credits = 5'(16 - (sent - drained));
            exp_wready  = !pending;
            exp_v       = pending && (exp_credits != 0);
            exp_rv      = (rq.size() != 0);
            exp_yumi    = r_retv && (rq.size() == 0);

            checkOutput("rnd_credits", credits_o, exp_credits);
            checkOutput("rnd_wready", host_wready_o, exp_wready);
            checkOutput("rnd_fwd_v", fwd_v_o, exp_v);
            checkOutput("rnd_rv", host_rv_o, exp_rv);
            checkOutput("rnd_yumi", ret_yumi_o, exp_yumi);
            if (exp_v) checkOutput("rnd_pkt", fwd_packet_o, pend_pkt);
            if (exp_rv) checkOutput("rnd_rdata", host_rdata_o, rq[0]);

            wt = r_wv && exp_wready;
            ft = exp_v && r_fr;
            rt = exp_rv && r_rr;
            yt = exp_yumi;
            tick();

            if (ft) begin
                pending = 0;
                sent++;
            end
            if (wt) begin
                wq.push_back(r_wdata);
                if (wq.size() == 4) begin
                    pend_pkt = {wq[3], wq[2], wq[1], wq[0]};
                    pending  = 1;
                    wq.delete();
                end
            end
            if (rt) begin
                void'(rq.pop_front());
                if (rq.size() == 0) drained++;
            end
            if (yt) begin
                rq.push_back(r_pkt[31:0]);
                rq.push_back(r_pkt[63:32]);
                ret_acc++;
            end
        end
        $display("[TB] random run sent=%0d drained=%0d", sent, drained);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
